// File: rtl/raw_readout_if.sv
// Output word stream of raw_readout: 16-bit data words with a valid/ready handshake.
// The master drives dout/dvalid and the slave drives dready.
interface raw_readout_if;
  logic [15:0] dout;
  logic        dvalid;
  logic        dready;

  modport master (output dout, output dvalid, input dready);
  modport slave  (input dout, input dvalid, output dready);
endinterface

// File: rtl/raw_readout.sv
// Captures a window of raw hit frames on each accepted L1A and ships it as a framed
// 16-bit stream: header, frames lane by lane, trailer. L1As arriving mid-event are dropped.
module raw_readout (
  input  logic           clk,
  input  logic           rst,
  input  logic [287:0]   raw_in,
  input  logic           l1a,
  input  logic [4:0]     win_len,
  raw_readout_if.master  daq,
  output logic           busy,
  output logic           l1a_drop,
  output logic [7:0]     drop_cnt
);

  localparam int unsigned NumLanes = 18;
  localparam logic [4:0]  LastLane = 5'd17;

  typedef enum logic [2:0] {StIdle, StCapture, StHdr, StData, StTrl} state_e;

  state_e      state_q, state_d;
  logic [4:0]  wl_q, wl_d;
  logic [4:0]  frame_q, frame_d;
  logic [4:0]  lane_q, lane_d;
  logic [11:0] evn_q, evn_d;
  logic [15:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // Window buffer, one 18-lane frame per entry; contents are never reset.
  logic [NumLanes-1:0][15:0] buf_q [32];
  logic                      buf_we;
  logic [4:0]                buf_waddr;

  logic [4:0]  rd_frame, rd_lane;
  logic [15:0] rd_word;
  logic [5:0]  nframes;
  logic        xfer, last_lane;

  assign xfer      = dvalid_q & daq.dready;
  assign last_lane = (lane_q == LastLane);
  assign nframes   = {1'b0, wl_q} + 6'd1;

  // Buffer address of the word that follows the one currently presented on dout.
  always_comb begin
    rd_frame = frame_q;
    rd_lane  = lane_q + 5'd1;
    if (state_q == StHdr) begin
      rd_frame = '0;
      rd_lane  = '0;
    end else if (last_lane) begin
      rd_frame = frame_q + 5'd1;
      rd_lane  = '0;
    end
  end

  assign rd_word = buf_q[rd_frame][rd_lane];

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= raw_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    wl_d       = wl_q;
    frame_d    = frame_q;
    lane_d     = lane_q;
    evn_d      = evn_q;
    dout_d     = dout_q;
    dvalid_d   = dvalid_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    buf_we     = 1'b0;
    buf_waddr  = frame_q;

    if (l1a && (state_q != StIdle)) begin
      drop_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (l1a) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          wl_d      = win_len;
          evn_d     = evn_q + 12'd1;
          frame_d   = 5'd1;
          state_d   = (win_len == 5'd0) ? StHdr : StCapture;
        end
      end
      StCapture: begin
        buf_we = 1'b1;
        if (frame_q == wl_q) begin
          state_d = StHdr;
        end else begin
          frame_d = frame_q + 5'd1;
        end
      end
      StHdr: begin
        // The header is loaded one cycle after entry so dout stays a pure register.
        if (!dvalid_q) begin
          dvalid_d = 1'b1;
          dout_d   = {4'hA, evn_q};
        end else if (xfer) begin
          state_d = StData;
          frame_d = '0;
          lane_d  = '0;
          dout_d  = rd_word;
        end
      end
      StData: begin
        if (xfer) begin
          if (last_lane && (frame_q == wl_q)) begin
            state_d = StTrl;
            dout_d  = {4'hE, 6'b0, nframes};
          end else begin
            frame_d = rd_frame;
            lane_d  = rd_lane;
            dout_d  = rd_word;
          end
        end
      end
      StTrl: begin
        if (xfer) begin
          dvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wl_q       <= '0;
      frame_q    <= '0;
      lane_q     <= '0;
      evn_q      <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wl_q       <= wl_d;
      frame_q    <= frame_d;
      lane_q     <= lane_d;
      evn_q      <= evn_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign daq.dout   = dout_q;
  assign daq.dvalid = dvalid_q;
  assign busy       = busy_q;
  assign l1a_drop   = drop_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_raw_readout.sv
// Bench for raw_readout: directed event sequence with random data and random backpressure,
// checked cycle by cycle against an event-level model of the readout.
module tb_raw_readout;

  logic         clk = 1'b0;
  logic         rst;
  logic [287:0] raw_in;
  logic         l1a;
  logic [4:0]   win_len;
  logic         busy;
  logic         l1a_drop;
  logic [7:0]   drop_cnt;

  raw_readout_if daq ();

  raw_readout dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .l1a      (l1a),
    .win_len  (win_len),
    .daq      (daq),
    .busy     (busy),
    .l1a_drop (l1a_drop),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Event-level model state.
  bit           m_busy;
  int           m_wl, m_cap_left, m_left, m_hdr_cyc, m_drops;
  logic [11:0]  m_evn;
  logic [287:0] frames[$];
  logic [15:0]  exp_q[$];
  bit           exp_drop;

  // Handshake monitor and stimulus controls.
  bit          pv, pr;
  logic [15:0] pd;
  int          n_xfer;
  logic [15:0] last_hdr;
  int          raw_mode, base;
  bit          rdy_rand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [287:0] next_raw();
    logic [287:0] r;
    if (raw_mode == 2) begin
      r = {18{16'(cyc - base)}};
    end else begin
      for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom();
    end
    return r;
  endfunction

  function automatic void build_expect();
    logic [287:0] fr;
    exp_q.delete();
    exp_q.push_back({4'hA, m_evn});
    foreach (frames[f]) begin
      fr = frames[f];
      for (int k = 0; k < 18; k++) exp_q.push_back(fr[k*16 +: 16]);
    end
    exp_q.push_back({4'hE, 6'b0, 6'(m_wl + 1)});
    m_left = exp_q.size();
  endfunction

  task automatic tick();
    logic [287:0] raw_c;
    logic [15:0]  w;
    bit           l1a_c, b0, acc;
    int           win_c;
    raw_c = raw_in;
    l1a_c = l1a;
    win_c = int'(win_len);
    pr    = daq.dready;
    b0    = m_busy;
    acc   = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    exp_drop = 1'b0;
    if (pv && pr) begin
      if (exp_q.size() == 0) begin
        chk("xfer_idle", 32'(pv & pr), 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("word", 32'(pd), 32'(w));
        if (m_left == 2 + 18 * (m_wl + 1)) last_hdr = pd;
        n_xfer++;
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
    end
    if (l1a_c) begin
      if (b0) begin
        exp_drop = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        acc       = 1'b1;
        m_busy    = 1'b1;
        m_evn     = m_evn + 12'd1;
        m_wl      = win_c;
        m_hdr_cyc = cyc + m_wl + 1;
        frames.delete();
        frames.push_back(raw_c);
        m_cap_left = m_wl;
        if (m_cap_left == 0) build_expect();
      end
    end
    if (!acc && m_cap_left > 0) begin
      frames.push_back(raw_c);
      m_cap_left--;
      if (m_cap_left == 0) build_expect();
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dvalid", 32'(daq.dvalid), 32'(m_busy && cyc >= m_hdr_cyc));
    chk("l1a_drop", 32'(l1a_drop), 32'(exp_drop));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    if (pv && !pr) chk("stall_hold", 32'(daq.dout), 32'(pd));
    pv          = daq.dvalid;
    pd          = daq.dout;
    l1a         = 1'b0;
    daq.dready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    raw_in      = next_raw();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic hard_reset();
    #3 rst = 1'b1;
    #1;
    chk("rst_dout", 32'(daq.dout), 32'd0);
    chk("rst_dvalid", 32'(daq.dvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_l1a_drop", 32'(l1a_drop), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    m_busy     = 1'b0;
    m_evn      = '0;
    m_drops    = 0;
    m_cap_left = 0;
    m_left     = 0;
    exp_q.delete();
    frames.delete();
    pv         = 1'b0;
    pd         = '0;
    l1a        = 1'b0;
    daq.dready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int n, t0;
    rst = 1'b1; l1a = 1'b0; win_len = '0; raw_in = '0; daq.dready = 1'b1;
    rdy_rand = 1'b0; raw_mode = 0; base = 0;
    m_busy = 1'b0; m_evn = '0; m_drops = 0; m_cap_left = 0; m_left = 0; m_hdr_cyc = 0;
    pv = 1'b0; pd = '0; n_xfer = 0; last_hdr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_dout", 32'(daq.dout), 32'd0);
    chk("init_dvalid", 32'(daq.dvalid), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_l1a_drop", 32'(l1a_drop), 32'd0);
    chk("init_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Single-frame event carrying a one-hot hit.
    win_len = 5'd0;
    n = $urandom_range(0, 287);
    raw_in = 288'h1 << n;
    l1a = 1'b1; n_xfer = 0; t0 = cyc;
    tick();
    wait_idle(40);
    chk("t1_words", 32'(n_xfer), 32'd20);
    chk("t1_idle_cycle", 32'(cyc - t0), 32'd22);
    chk("t1_hdr", 32'(last_hdr), 32'hA001);

    // Full 32-frame window, frame id in every lane, no backpressure.
    win_len = 5'd31; raw_mode = 2; base = cyc;
    raw_in = next_raw();
    l1a = 1'b1; n_xfer = 0; t0 = cyc;
    tick();
    wait_idle(700);
    raw_mode = 0;
    chk("t2_words", 32'(n_xfer), 32'd578);
    chk("t2_idle_cycle", 32'(cyc - t0), 32'd611);

    // Random backpressure on a 4-frame event.
    win_len = 5'd3; rdy_rand = 1'b1;
    l1a = 1'b1; n_xfer = 0;
    tick();
    wait_idle(1000);
    rdy_rand = 1'b0;
    chk("t3_words", 32'(n_xfer), 32'd74);

    // Drops at T+1, T+5 and the trailer cycle; the cycle after the trailer is accepted.
    hard_reset();
    win_len = 5'd2;
    for (int i = 0; i <= 60; i++) begin
      l1a = (i == 0 || i == 1 || i == 5 || i == 59 || i == 60);
      tick();
    end
    wait_idle(100);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("t4_hdr2", 32'(last_hdr), 32'hA002);

    // Drop counter saturation, then reset in the middle of the data phase.
    win_len = 5'd31;
    l1a = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      l1a = 1'b1;
      tick();
    end
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
    repeat (20) tick();
    hard_reset();
    win_len = 5'd0;
    l1a = 1'b1;
    tick();
    wait_idle(40);
    chk("t5_hdr_after_rst", 32'(last_hdr), 32'hA001);

    // Event number wrap through 4095 -> 0 -> 1.
    for (int e = 0; e < 4096; e++) begin
      l1a = 1'b1;
      tick();
      wait_idle(40);
      if (e == 4093) chk("t6_hdr_fff", 32'(last_hdr), 32'hAFFF);
      if (e == 4094) chk("t6_hdr_000", 32'(last_hdr), 32'hA000);
    end
    chk("t6_hdr_001", 32'(last_hdr), 32'hA001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/raw_readout.md
# raw_readout

Captures a window of delayed raw wire-group hits on each accepted L1A and ships them to the DAQ path as a framed stream of 16-bit words with a valid/ready handshake. Sits directly downstream of the raw hit delay line. Its 288-bit input is the delay line's output, already aligned so the frame present in the L1A cycle is the first frame of the event window. The block owns the window buffer, event numbering, header/trailer framing, and L1A drop accounting while an event is in flight.

## Interface
- Parameters: none (frame width 288 and max window 32 are fixed).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raw_in  in  288  delayed raw hits, one frame per clk.
- l1a  in  1  L1A accept strobe, 1-cycle pulse.
- win_len  in  5  window length minus one; frames captured = win_len+1 (1..32); sampled only on accepted l1a.
- dout  out  16  output data word, registered.
- dvalid  out  1  dout valid.
- dready  in  1  consumer ready; word transfers when dvalid & dready.
- busy  out  1  event in flight (state != IDLE).
- l1a_drop  out  1  1-cycle pulse: l1a arrived while busy and was discarded.
- drop_cnt  out  8  count of dropped L1As, saturates at 255.

## Operation
- Internal window buffer: 32 x 288 (RAM), read/write by frame index; contents not reset.
- Event counter evn: 12-bit, reset 0, incremented on each accepted l1a; value after increment goes in the header (first event = 1, wraps 4095->0).
- States: IDLE, CAPTURE, HDR, DATA, TRL.
- IDLE: on l1a, write raw_in to frame 0, latch wl = win_len, increment evn, go CAPTURE (if wl=0 go directly to HDR).
- CAPTURE: write raw_in to frame f = 1..wl on consecutive cycles; after writing frame wl, go HDR.
- HDR: present {4'hA, evn[11:0]}; on transfer go DATA.
- DATA: for frame f = 0..wl, word k = 0..17, present raw[f][16k+15:16k] (k=0 first); after word 17 of frame wl transfers, go TRL.
- TRL: present {4'hE, 6'b0, nframes[5:0]} with nframes = wl+1; on transfer go IDLE.
- Words per event = 2 + 18*(wl+1) (20..578).
- l1a while state != IDLE (including the cycle the trailer transfers): dropped; l1a_drop pulses the following cycle; drop_cnt increments, holds at 255.
- win_len changes outside the l1a cycle have no effect on the event in flight.

## Timing
- Reset values: dout=0, dvalid=0, busy=0, l1a_drop=0, drop_cnt=0, evn=0, state IDLE. Reset mid-event aborts it immediately; no trailer is sent.
- l1a at cycle T: frame i = raw_in sampled at T+i, i = 0..wl; busy=1 from T+1.
- Header dvalid rises at T+wl+2 (registered output).
- dvalid/dout held stable while dvalid & !dready. With dready held 1: one word per cycle, no bubbles between header, data and trailer.
- Trailer transferred at cycle X: dvalid=0 and busy=0 at X+1. An l1a at X+1 is accepted.
- dready deassertion of any length at any word stalls the stream without loss or duplication.

## Test plan
- Single event, win_len=0, dready=1, raw_in frame = 288'h1 << n at T: header 16'hA001 at T+2, 18 data words (word n/16 = 1<<(n%16), others 0), trailer 16'hE001; busy low at T+22.
- win_len=31, raw_in = incrementing frame id in each 16-bit lane: 578 words, frame order 0..31, trailer 16'hE020, no bubbles.
- Random dready (50%) during a win_len=3 event: reconstructed 72 data words match the captured frames exactly; dout never changes while dvalid & !dready.
- l1a pulses at T+1, T+5 and at the trailer-transfer cycle of a win_len=2 event: three l1a_drop pulses, drop_cnt=3, next event header evn=2. l1a at the trailer cycle +1 is accepted.
- 300 l1a pulses while busy: drop_cnt saturates at 255. Assert rst mid-DATA: all outputs return to their reset values asynchronously; the next event header is 16'hA001.
- 4097 accepted events, win_len=0: header evn wraps from 16'hAFFF to 16'hA000 to 16'hA001.
